// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
// Latency: none, declarations only.
// Backpressure: not applicable.
package serial_frame_pkg;

    // Receiver FSM: wait for start, collect data, check parity, check stop
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line levels of the one-bit-per-cycle frame format
    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in/parallel-out register, LSB-first (new bits enter at the MSB end).
// Latency: one edge per shifted bit; after WIDTH shifts the first bit sits in bit 0.
// Backpressure: none; shifts whenever shift_en is high, clear has priority.
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] shift_q;

    // Shift right so the earliest bit ends up in the LSB after WIDTH shifts
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {serial_in, shift_q[WIDTH-1:1]};
        end
    end

    assign parallel_out = shift_q;

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, even parity, stop bit, one bit per CLK.
// Latency: data_valid rises WIDTH+2 edges after the edge that samples the start bit.
// Backpressure: one-entry output register; a good frame completing while it is still full is dropped with an overrun pulse.
module serial_frame_deserializer
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             serial_in,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_word;
    logic             par_bad;

    logic             start_seen;
    logic             shift_en;
    logic             stop_good;
    logic             stop_bad;
    logic             consume;
    logic             load;

    // Frame-position decodes and output-register decisions for this edge
    always_comb begin
        start_seen = (state == IDLE) && (serial_in == START_BIT);
        shift_en   = (state == DATA);
        stop_good  = (state == STOP) && (serial_in == STOP_BIT);
        stop_bad   = (state == STOP) && (serial_in != STOP_BIT);
        consume    = data_valid && data_ready;
        // A slot freed by a handshake at this same edge can take the new word
        load       = stop_good && (!data_valid || data_ready);
    end

    sipo_shift_reg #(
        .WIDTH(WIDTH)
    ) u_sipo (
        .CLK         (CLK),
        .RST         (RST),
        .clear       (start_seen),
        .shift_en    (shift_en),
        .serial_in   (serial_in),
        .parallel_out(shift_word)
    );

    // Frame FSM, parity check and registered output stage
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_seen) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    // Data plus parity must hold an even number of ones
                    par_bad <= (^shift_word) ^ serial_in;
                    state   <= STOP;
                end
                STOP: begin
                    // The stop bit is never reused as a start bit
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (load) begin
                data_out   <= shift_word;
                parity_err <= par_bad;
                data_valid <= 1'b1;
            end else if (consume) begin
                data_valid <= 1'b0;
            end

            if (stop_good && !load) begin
                overrun <= 1'b1;
            end

            if (stop_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
module tb_serial_frame_deserializer;
    import serial_frame_pkg::*;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         serial_in = 1'b0;
    logic         data_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;

    always #5 CLK = ~CLK;

    serial_frame_deserializer #(
        .WIDTH(W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .serial_in (serial_in),
        .data_ready(data_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    typedef struct packed {
        logic         vld;
        logic [W-1:0] dat;
        logic         pe;
        logic         ferr;
        logic         ovr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: a one-entry mailbox holding the word the consumer has not yet taken
    logic         m_full = 1'b0;
    logic [W-1:0] m_word = '0;
    logic         m_pe   = 1'b0;

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one line bit and data_ready for the next edge and record what that edge must produce
    task automatic tick(input logic s, input logic r, input logic is_stop,
                        input logic [W-1:0] d, input logic pe);
        exp_t e;
        logic taken;
        @(negedge CLK);
        serial_in  = s;
        data_ready = r;
        e     = '0;
        taken = m_full && r;
        if (taken) m_full = 1'b0;
        if (is_stop && s != STOP_BIT) begin
            e.ferr = 1'b1;
        end else if (is_stop) begin
            if (!m_full) begin
                m_full = 1'b1;
                m_word = d;
                m_pe   = pe;
            end else begin
                e.ovr = 1'b1;
            end
        end
        e.vld = m_full;
        e.dat = m_word;
        e.pe  = m_pe;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) tick(IDLE_LEVEL, pick_ready(mode), 1'b0, '0, 1'b0);
    endtask

    // Build a frame from its field values; flip inverts the correct parity bit
    task automatic send_frame(input logic [W-1:0] d, input logic flip, input logic stop,
                              input int body_mode, input int stop_mode);
        logic p;
        logic ones_odd;
        ones_odd = 1'b0;
        for (int i = 0; i < W; i++) ones_odd = ones_odd ^ d[i];
        p = ones_odd ^ flip;
        tick(START_BIT, pick_ready(body_mode), 1'b0, d, 1'b0);
        for (int i = 0; i < W; i++) tick(d[i], pick_ready(body_mode), 1'b0, d, 1'b0);
        tick(p, pick_ready(body_mode), 1'b0, d, 1'b0);
        tick(stop, pick_ready(stop_mode), 1'b1, d, ones_odd ^ p);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({data_out, data_valid, parity_err, frame_err, overrun} !== '0) begin
            fails++;
            $display("FAIL %s: data_out=%h valid=%b perr=%b ferr=%b ovr=%b, required all zero",
                     name, data_out, data_valid, parity_err, frame_err, overrun);
        end
    endtask

    // Monitor: each entry describes the outputs right after one edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({data_valid, frame_err, overrun} !== {e.vld, e.ferr, e.ovr}) begin
                    fails++;
                    $display("FAIL flags @%0t: valid/ferr/ovr=%b%b%b, required %b%b%b",
                             $time, data_valid, frame_err, overrun, e.vld, e.ferr, e.ovr);
                end
                if (e.vld) begin
                    tests++;
                    if (data_out !== e.dat || parity_err !== e.pe) begin
                        fails++;
                        $display("FAIL word @%0t: data_out=%h perr=%b, required %h perr=%b",
                                 $time, data_out, parity_err, e.dat, e.pe);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check_zero("reset_state");
        RST = 1'b1;
        idle(2, 1);

        // Good frame 0xA5, consumer always ready
        send_frame(8'hA5, 1'b0, STOP_BIT, 1, 1);
        idle(2, 1);

        // Reset after the 4th data bit of a frame
        tick(START_BIT, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, '0, 1'b0);
        @(posedge CLK);
        #3;
        RST    = 1'b0;
        m_full = 1'b0;
        m_word = '0;
        m_pe   = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check_zero("reset_mid_frame");
        end
        serial_in = IDLE_LEVEL;
        RST       = 1'b1;
        send_frame(8'h3C, 1'b0, STOP_BIT, 1, 1);
        idle(3, 1);

        // Parity error still delivers the word
        send_frame(8'h01, 1'b1, STOP_BIT, 1, 1);
        idle(2, 1);

        // Framing error, then an immediate good frame
        send_frame(8'hFF, 1'b0, 1'b1, 1, 1);
        send_frame(8'h5A, 1'b0, STOP_BIT, 1, 1);
        idle(2, 1);

        // Overrun: consumer stalled across two back-to-back frames
        send_frame(8'h11, 1'b0, STOP_BIT, 0, 0);
        send_frame(8'h22, 1'b0, STOP_BIT, 0, 0);
        idle(2, 0);
        idle(3, 1);

        // Accept and reload at the same stop edge
        send_frame(8'h11, 1'b0, STOP_BIT, 0, 0);
        send_frame(8'h22, 1'b0, STOP_BIT, 0, 1);
        idle(3, 1);

        // Randomized frames, gaps, errors and consumer stalls
        for (int n = 0; n < 60; n++) begin
            send_frame(W'($urandom), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0) ? 1'b1 : STOP_BIT,
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            idle(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        idle(4, 1);

        repeat (3) @(posedge CLK);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
